// File: rtl/ahb_clac_pkg.sv
// Shared encodings for the clac AHB-Lite slave: register map, bus codes, FSM states.
package ahb_clac_pkg;

  localparam int unsigned OFF_CTRL   = 32'h00;
  localparam int unsigned OFF_OPA    = 32'h04;
  localparam int unsigned OFF_OPB    = 32'h08;
  localparam int unsigned OFF_RESULT = 32'h0C;
  localparam int unsigned OFF_STATUS = 32'h10;

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_OPA    = 3'd1;
  localparam logic [2:0] IDX_OPB    = 3'd2;
  localparam logic [2:0] IDX_RESULT = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Accepted transfer carried from the address phase into the data phase.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] idx;
  } dp_t;

endpackage

// File: rtl/ahb_clac_err.sv
// Two-cycle AHB ERROR responder: wait state with ERROR, then ready with ERROR.
module ahb_clac_err
  import ahb_clac_pkg::*;
(
  input  logic hclk,
  input  logic hrst,
  input  logic err_req,
  output logic hreadyout,
  output logic hresp
);

  always_ff @(posedge hclk) begin
    if (hrst) begin
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end else if (!hreadyout) begin
      hreadyout <= 1'b1;
      hresp     <= HRESP_ERROR;
    end else if (err_req) begin
      hreadyout <= 1'b0;
      hresp     <= HRESP_ERROR;
    end else begin
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
    end
  end

endmodule

// File: rtl/ahb_clac_slv.sv
// AHB-Lite slave front end for clac: operand/mode registers, calc sequencer, result capture.
module ahb_clac_slv
  import ahb_clac_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [31:0]       hrdata,
  output logic              clac_ctrl,
  output logic [1:0]        clac_mode,
  output logic [15:0]       opcode_a,
  output logic [15:0]       opcode_b,
  input  logic [31:0]       clac_result
);

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] result;
  logic        drop;
  dp_t         dp;

  logic        accept_c, bad_c, rd_c, status_rd_c;
  logic        ctrl_wr_c, opa_wr_c, opb_wr_c;
  logic [2:0]  idx_c;
  logic [31:0] rdata_c;
  logic        unused;

  assign unused = ^hwdata[31:16];

  assign accept_c = hsel && hready &&
                    (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  assign bad_c = (haddr > ADDR_W'(OFF_STATUS)) || (haddr[1:0] != 2'b00) ||
                 (hsize != HSIZE_WORD) ||
                 (hwrite && (haddr == ADDR_W'(OFF_RESULT) || haddr == ADDR_W'(OFF_STATUS)));
  assign idx_c       = haddr[4:2];
  assign rd_c        = accept_c && !bad_c && !hwrite;
  assign status_rd_c = rd_c && (idx_c == IDX_STATUS);

  // Data-phase write strobes; hwdata is valid on the edge that ends the data phase.
  assign ctrl_wr_c = dp.valid && dp.write && (dp.idx == IDX_CTRL);
  assign opa_wr_c  = dp.valid && dp.write && (dp.idx == IDX_OPA);
  assign opb_wr_c  = dp.valid && dp.write && (dp.idx == IDX_OPB);

  always_comb begin
    rdata_c = '0;
    case (idx_c)
      IDX_CTRL:   rdata_c = {29'b0, clac_mode, 1'b0};
      IDX_OPA:    rdata_c = {16'b0, opcode_a};
      IDX_OPB:    rdata_c = {16'b0, opcode_b};
      IDX_RESULT: rdata_c = result;
      IDX_STATUS: rdata_c = {30'b0, drop, state == ST_DONE};
      default:    rdata_c = '0;
    endcase
  end

  ahb_clac_err u_err (
    .hclk      (hclk),
    .hrst      (hrst),
    .err_req   (accept_c && bad_c),
    .hreadyout (hreadyout),
    .hresp     (hresp)
  );

  // Read data is captured on the address-phase edge so it is valid for the whole data phase.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dp        <= '0;
      clac_ctrl <= 1'b0;
      clac_mode <= '0;
      opcode_a  <= '0;
      opcode_b  <= '0;
      result    <= '0;
      drop      <= 1'b0;
      hrdata    <= '0;
    end else begin
      dp <= '{valid: accept_c && !bad_c, write: hwrite, idx: idx_c};
      if (rd_c) hrdata <= rdata_c;
      if (status_rd_c) drop <= 1'b0;
      case (state)
        ST_CALC: begin
          if (ctrl_wr_c || opa_wr_c || opb_wr_c) drop <= 1'b1;
          if (cnt == 4'(CALC_CYCLES - 1)) begin
            result    <= clac_result;
            state     <= ST_DONE;
            clac_ctrl <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          if (opa_wr_c)  opcode_a  <= hwdata[15:0];
          if (opb_wr_c)  opcode_b  <= hwdata[15:0];
          if (ctrl_wr_c) clac_mode <= hwdata[2:1];
          if (ctrl_wr_c && hwdata[0]) begin
            state     <= ST_CALC;
            cnt       <= '0;
            clac_ctrl <= 1'b1;
          end else if (state == ST_DONE && status_rd_c) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_clac_slv.sv
// Directed bench for ahb_clac_slv with a behavioural clac and single-master bus.
module tb_ahb_clac_slv;

  localparam int unsigned CC = 4;

  logic        hclk = 1'b0;
  logic        hrst, hsel, hwrite, hready, hreadyout, hresp, clac_ctrl;
  logic [7:0]  haddr;
  logic [1:0]  htrans, clac_mode;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata, clac_result;
  logic [15:0] opcode_a, opcode_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  always_comb begin
    case (clac_mode)
      2'b00:   clac_result = {16'b0, opcode_a & opcode_b};
      2'b01:   clac_result = {16'b0, opcode_a | opcode_b};
      2'b10:   clac_result = {16'b0, opcode_a ^ opcode_b};
      default: clac_result = 32'(opcode_a) + 32'(opcode_b);
    endcase
  end

  ahb_clac_slv #(.ADDR_W(8), .CALC_CYCLES(CC)) dut (
    .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .clac_ctrl(clac_ctrl),
    .clac_mode(clac_mode), .opcode_a(opcode_a), .opcode_b(opcode_b),
    .clac_result(clac_result)
  );

  typedef struct {
    string       nm;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'b010;
  endtask

  task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a; hsize = 3'b010;
    tick();
    bus_idle();
    hwdata = d;
    tick();
  endtask

  task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a; hsize = 3'b010;
    tick();
    bus_idle();
    d = hrdata;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_rd(a, d);
    chk(nm, d, exp);
  endtask

  task automatic ahb_err(input string nm, input logic [7:0] a, input logic wr,
                         input logic [2:0] sz, input logic [31:0] d);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    tick();
    chk({nm, "_c1"}, {30'b0, hreadyout, hresp}, 32'h1);
    bus_idle();
    hwdata = d;
    tick();
    chk({nm, "_c2"}, {30'b0, hreadyout, hresp}, 32'h3);
    tick();
    chk({nm, "_end"}, {30'b0, hreadyout, hresp}, 32'h2);
  endtask

  // Single-cycle non-transfer (BUSY or deselected) followed by its would-be data phase.
  task automatic ahb_nontransfer(input logic s, input logic [1:0] t, input logic [7:0] a,
                                 input logic [31:0] d);
    hsel = s; htrans = t; hwrite = 1'b1; haddr = a; hsize = 3'b010;
    tick();
    bus_idle();
    hwdata = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hrst = 1'b1; hwdata = '0;
    bus_idle();
    tick(); tick();
    hrst = 1'b0;
    chk("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
    chk("rst_hresp", {31'b0, hresp}, 32'h0);
    chk("rst_ctrl_out", {31'b0, clac_ctrl}, 32'h0);
    chk("rst_hrdata", hrdata, 32'h0);

    vt[0]  = '{"rst_opa",    1'b0, 8'h04, 32'h0,        32'h0};
    vt[1]  = '{"rst_opb",    1'b0, 8'h08, 32'h0,        32'h0};
    vt[2]  = '{"rst_ctrl",   1'b0, 8'h00, 32'h0,        32'h0};
    vt[3]  = '{"rst_result", 1'b0, 8'h0C, 32'h0,        32'h0};
    vt[4]  = '{"rst_status", 1'b0, 8'h10, 32'h0,        32'h0};
    vt[5]  = '{"wr_opa",     1'b1, 8'h04, 32'hDEAD1234, 32'h0};
    vt[6]  = '{"rd_opa",     1'b0, 8'h04, 32'h0,        32'h00001234};
    vt[7]  = '{"wr_opb",     1'b1, 8'h08, 32'hFFFF00FF, 32'h0};
    vt[8]  = '{"rd_opb",     1'b0, 8'h08, 32'h0,        32'h000000FF};
    vt[9]  = '{"wr_mode",    1'b1, 8'h00, 32'h00000006, 32'h0};
    vt[10] = '{"rd_ctrl",    1'b0, 8'h00, 32'h0,        32'h00000006};
    vt[11] = '{"rd_nostart", 1'b0, 8'h10, 32'h0,        32'h0};
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) ahb_wr(vt[i].addr, vt[i].data);
      else rd_chk(vt[i].nm, vt[i].addr, vt[i].exp);
    end

    // ADD 0x1234+0x00FF; clac_ctrl must be high for exactly CC cycles.
    ahb_wr(8'h00, 32'h7);
    chk("t1_opa_out", {16'b0, opcode_a}, 32'h1234);
    chk("t1_mode_out", {30'b0, clac_mode}, 32'h3);
    for (int i = 0; i <= CC; i++) begin
      chk($sformatf("t1_ctrl_cyc%0d", i), {31'b0, clac_ctrl}, (i < CC) ? 32'h1 : 32'h0);
      tick();
    end
    rd_chk("t1_status", 8'h10, 32'h1);
    rd_chk("t1_result", 8'h0C, 32'h00001333);
    rd_chk("t1_status_clr", 8'h10, 32'h0);

    // AND; first STATUS read lands on the CALC->DONE edge.
    ahb_wr(8'h04, 32'hF0F0);
    ahb_wr(8'h08, 32'h0FF0);
    ahb_wr(8'h00, 32'h1);
    repeat (CC - 1) tick();
    rd_chk("t2_status_race", 8'h10, 32'h0);
    rd_chk("t2_status1", 8'h10, 32'h1);
    rd_chk("t2_status2", 8'h10, 32'h0);
    rd_chk("t2_result", 8'h0C, 32'h000000F0);

    // Error responses leave every register alone.
    ahb_err("t3_rd14", 8'h14, 1'b0, 3'b010, 32'h0);
    ahb_err("t3_wr0c", 8'h0C, 1'b1, 3'b010, 32'hFFFFFFFF);
    ahb_err("t3_wr10", 8'h10, 1'b1, 3'b010, 32'hFFFFFFFF);
    ahb_err("t3_misal", 8'h06, 1'b1, 3'b010, 32'h5555);
    rd_chk("t3_result", 8'h0C, 32'h000000F0);
    rd_chk("t3_opa", 8'h04, 32'h0000F0F0);

    // Operand write during CALC is dropped and flagged.
    ahb_wr(8'h04, 32'h1234);
    ahb_wr(8'h08, 32'h00FF);
    ahb_wr(8'h00, 32'h7);
    ahb_wr(8'h04, 32'hAAAA);
    chk("t4_opa_stable", {16'b0, opcode_a}, 32'h1234);
    tick(); tick();
    ahb_err("t4_status_hsize", 8'h10, 1'b0, 3'b000, 32'h0);
    rd_chk("t4_status", 8'h10, 32'h3);
    rd_chk("t4_status_clr", 8'h10, 32'h0);
    rd_chk("t4_opa", 8'h04, 32'h1234);
    rd_chk("t4_result", 8'h0C, 32'h00001333);

    // Reset mid-CALC, then a fresh XOR calculation.
    rd_chk("t5_pre_result", 8'h0C, 32'h00001333);
    ahb_wr(8'h00, 32'h3);
    tick();
    hrst = 1'b1;
    tick();
    hrst = 1'b0;
    chk("t5_ctrl_out", {31'b0, clac_ctrl}, 32'h0);
    chk("t5_hready", {31'b0, hreadyout}, 32'h1);
    chk("t5_hresp", {31'b0, hresp}, 32'h0);
    chk("t5_hrdata", hrdata, 32'h0);
    chk("t5_ops", {opcode_a, opcode_b}, 32'h0);
    chk("t5_mode", {30'b0, clac_mode}, 32'h0);
    rd_chk("t5_result", 8'h0C, 32'h0);
    rd_chk("t5_status", 8'h10, 32'h0);
    ahb_wr(8'h04, 32'h00F0);
    ahb_wr(8'h08, 32'h0F00);
    ahb_wr(8'h00, 32'h5);
    repeat (CC + 1) tick();
    rd_chk("t5_new_status", 8'h10, 32'h1);
    rd_chk("t5_new_result", 8'h0C, 32'h00000FF0);

    // ADD carry into bit 16; BUSY and deselected writes are ignored.
    ahb_wr(8'h04, 32'hFFFF);
    ahb_wr(8'h08, 32'hFFFF);
    ahb_wr(8'h00, 32'h7);
    repeat (CC + 1) tick();
    rd_chk("t6_status", 8'h10, 32'h1);
    rd_chk("t6_result", 8'h0C, 32'h0001FFFE);
    ahb_nontransfer(1'b1, 2'b01, 8'h04, 32'h5555);
    rd_chk("t6_busy_opa", 8'h04, 32'h0000FFFF);
    ahb_nontransfer(1'b0, 2'b10, 8'h04, 32'h5555);
    rd_chk("t6_nosel_opa", 8'h04, 32'h0000FFFF);
    chk("t6_hresp", {31'b0, hresp}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
